multi_pulse_generator: RTL
==========================

Name: multi_pulse_generator

Overview:
- Parametrised, multi-channel successor to the single one-shot edge pulser.
- Per channel: selectable edge detection (rise/fall/both) and a programmable pulse length in clock cycles.
- Optional retrigger extends an active pulse; a sticky overrun flag records edges lost while a pulse is active.
- Used wherever control logic needs clean, fixed-width strobes from level inputs, such as interrupt strobes and enable windows.

Parameters:
- NUM_CH, 4: number of independent channels (1..32).
- LEN_W, 8: width of the pulse-length field; maximum pulse is 2^LEN_W-1 cycles.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- trigger  in  NUM_CH  level inputs, one per channel; synchronous to clk unless PULSE_GEN_SYNC_EN.
- edge_mode  in  2  shared edge select: 00 rise, 01 fall, 10 both, 11 disabled.
- pulse_len  in  LEN_W  shared pulse length in cycles; 0 is treated as 1.
- retrig_en  in  1  1 = edge during an active pulse reloads the length.
- clr_overrun  in  NUM_CH  per-channel clear of the sticky overrun flag.
- pulse  out  NUM_CH  registered output pulses.
- overrun  out  NUM_CH  sticky flag: an edge was dropped.

Behaviour:
- Reset (rst high at posedge): pulse=0, overrun=0, all counters=0, trigger history=0, all channels IDLE.
- Reset is evaluated before all other inputs. Reset mid-pulse terminates the pulse on the next cycle.
- History resets to 0: a trigger high on the first post-reset sample is a rising edge.
- Edge detect per channel ch, with d the previous sample of trigger[ch]:
  - rise = trigger & ~d
  - fall = ~trigger & d
  - both = rise | fall
  - mode 11 = no edge
- The history register updates every cycle regardless of mode or state.
- Effective length: L = (pulse_len==0) ? 1 : pulse_len. L is sampled at the detecting clock edge; later changes to pulse_len do not affect an active pulse.
- Latency: edge detected at posedge N -> pulse[ch] high from posedge N through posedge N+L, i.e. exactly L cycles, then low.
- Per-channel FSM, 2 states:
  - IDLE: pulse=0. On edge -> ACTIVE, cnt=L-1, pulse=1.
  - ACTIVE: pulse=1. If cnt==0 and no accepted edge -> IDLE, pulse=0. Otherwise cnt decrements.
  - Edge in ACTIVE with retrig_en=1: cnt reloads to L-1 and the pulse stays high with no gap. The new pulse ends L cycles after the retrigger edge.
  - Edge in ACTIVE with retrig_en=0: the edge is ignored, overrun[ch] is set, and the pulse length is unaffected.
  - Edge in the same cycle cnt==0 with retrig_en=0: ignored, overrun set, and the pulse falls. The channel cannot restart until an edge is seen in IDLE.
  - Edge in the same cycle cnt==0 with retrig_en=1: reload; the pulse is continuous.
- Overrun: set dominates clear when set and clr_overrun coincide in the same cycle. Otherwise clr_overrun[ch]=1 clears the flag next cycle.
- edge_mode change: takes effect on the next sample. The history is unaffected, so switching mode can create an edge if the current level/history qualifies. Mode 11 lets active pulses finish normally.
- Channels are fully independent and share only configuration inputs.
- Counter arithmetic is LEN_W bits and never underflows (guarded by the state).

Optional Feature:
- Macro: PULSE_GEN_SYNC_EN.
- Defined: each trigger bit passes through a 2-flop synchronizer (reset to 0) before edge detection. Input-to-pulse latency grows by 2 cycles, and asynchronous triggers are permitted.
- Undefined: triggers feed edge detection directly with the latency stated above, and inputs must be synchronous to clk.

Decomposition:
- Package pulse_gen_pkg holds:
  - edge_mode encodings: EDGE_RISE=2'b00, EDGE_FALL=2'b01, EDGE_BOTH=2'b10, EDGE_OFF=2'b11.
  - Channel state enum: ST_IDLE, ST_ACTIVE.
- Sub-module pulse_gen_ch: one channel containing history flop, edge select, FSM, counter and overrun flag. The top level generates NUM_CH instances and the optional synchronizer.

Test Plan:
- Basic rise: mode=00, len=3, trigger[0] 0->1 held high → pulse[0] high exactly 3 cycles, starting the cycle after the edge sample; no repeat while the level is held.
- Both edges with len=0: mode=10, trigger[1] high 5 cycles then low → two 1-cycle pulses, one per transition; overrun stays 0.
- Retrigger: len=4, retrig_en=1, second rise 2 cycles after the first → pulse continuous for 2+4=6 cycles; overrun=0.
- Overrun:
  - Same pattern with retrig_en=0 → pulse exactly 4 cycles, overrun[2]=1.
  - clr_overrun pulse clears the flag.
  - Simultaneous clear and new drop keeps the flag at 1.
- Reset mid-pulse: len=10, rst at cycle 3 → pulse low the next cycle. Trigger still high after reset → new pulse.
- Independence/mode off: channels 0..3 triggered on staggered cycles with different edges → correct per-channel pulses. mode=11 during an active pulse → pulse completes and no new pulses start. With PULSE_GEN_SYNC_EN, all responses shift by 2 cycles.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the multi-channel pulse generator:
// edge-select encodings and the per-channel state type.
package pulse_gen_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } ch_state_e;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse-generator channel: trigger history, edge select,
// two-state FSM with down-counter, and sticky overrun flag.
module pulse_gen_ch
  import pulse_gen_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trig_i,
  input  logic [1:0]       edge_mode_i,
  input  logic [LEN_W-1:0] pulse_len_i,
  input  logic             retrig_en_i,
  input  logic             clr_overrun_i,
  output logic             pulse_o,
  output logic             overrun_o
);

  ch_state_e        state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             hist_q;
  logic             pulse_q;
  logic             overrun_q;
  logic             overrun_d;
  logic             edgeDet;
  logic             dropEdge;
  logic [LEN_W-1:0] reloadVal;

  // Qualify the current sample against the previous one using the shared mode.
  always_comb begin
    edgeDet = 1'b0;
    case (edge_mode_i)
      EDGE_RISE: edgeDet = trig_i & ~hist_q;
      EDGE_FALL: edgeDet = ~trig_i & hist_q;
      EDGE_BOTH: edgeDet = trig_i ^ hist_q;
      default:   edgeDet = 1'b0;
    endcase
  end

  // Counter load value L-1, where a zero length behaves as a one-cycle pulse;
  // an edge that arrives mid-pulse without retrigger is dropped and flagged,
  // and a new drop wins over a simultaneous clear.
  always_comb begin
    reloadVal = (pulse_len_i == '0) ? '0 : pulse_len_i - LEN_W'(1);
    dropEdge  = edgeDet & (state_q == ST_ACTIVE) & ~retrig_en_i;
    overrun_d = dropEdge | (overrun_q & ~clr_overrun_i);
  end

  // Channel FSM: history, counter, registered pulse and sticky flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hist_q    <= 1'b0;
      pulse_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      hist_q    <= trig_i;
      overrun_q <= overrun_d;
      case (state_q)
        ST_IDLE: begin
          if (edgeDet) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= reloadVal;
            pulse_q <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (edgeDet && retrig_en_i) begin
            cnt_q   <= reloadVal;
            pulse_q <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            pulse_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_o   = pulse_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Multi-channel edge-triggered pulse generator. Each channel turns an edge
// on its level input into a fixed-length strobe. Define PULSE_GEN_SYNC_EN to
// insert a 2-flop synchronizer on every trigger bit (adds 2 cycles latency
// and allows asynchronous triggers).
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] trigger_i,
  input  logic [1:0]        edge_mode_i,
  input  logic [LEN_W-1:0]  pulse_len_i,
  input  logic              retrig_en_i,
  input  logic [NUM_CH-1:0] clr_overrun_i,
  output logic [NUM_CH-1:0] pulse_o,
  output logic [NUM_CH-1:0] overrun_o
);

  logic [NUM_CH-1:0] trigSrc;

`ifdef PULSE_GEN_SYNC_EN
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  // Two-stage synchronizer bringing asynchronous triggers into the clock domain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= trigger_i;
      sync2_q <= sync1_q;
    end
  end

  assign trigSrc = sync2_q;
`else
  assign trigSrc = trigger_i;
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pulse_gen_ch #(
      .LEN_W(LEN_W)
    ) u_ch (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .trig_i        (trigSrc[ch]),
      .edge_mode_i   (edge_mode_i),
      .pulse_len_i   (pulse_len_i),
      .retrig_en_i   (retrig_en_i),
      .clr_overrun_i (clr_overrun_i[ch]),
      .pulse_o       (pulse_o[ch]),
      .overrun_o     (overrun_o[ch])
    );
  end

endmodule
